// File: rtl/axis_sink_decoder.sv
// Run-length sink packet decoder: accumulates per-output fire counts and total cycles,
// then streams NUM_OUT count words plus one cycle-total word on m_axis when the end marker arrives.
module axis_sink_decoder #(
  parameter int NUM_OUT     = 4,
  parameter int RUN_WIDTH   = 8,
  parameter int IN_WIDTH    = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic [IN_WIDTH-1:0]    s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [COUNT_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   o_dbg_state
);

  localparam int IDX_W = $clog2(NUM_OUT + 1);
  localparam logic [COUNT_WIDTH-1:0] SAT_MAX = '1;

  // Handshakes: a beat transfers on a rising edge where tvalid && tready are both high;
  // m_axis tdata/tlast stay stable while tvalid && !tready, and tvalid never drops before transfer.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [COUNT_WIDTH-1:0] r_count [NUM_OUT];
  logic [COUNT_WIDTH-1:0] r_cycles;
  logic [IDX_W-1:0]       r_idx;

  logic [RUN_WIDTH-1:0]   w_run_len;
  logic [NUM_OUT-1:0]     w_fire;
  logic [COUNT_WIDTH:0]   w_run_ext;
  logic                   w_s_hs;
  logic                   w_m_hs;
  logic                   w_last_beat;
  logic                   w_unused_tdata;
  logic [COUNT_WIDTH-1:0] w_words [NUM_OUT+1];

  assign w_run_len      = s_axis_tdata[IN_WIDTH-1 -: RUN_WIDTH];
  assign w_fire         = s_axis_tdata[IN_WIDTH-RUN_WIDTH-1 -: NUM_OUT];
  assign w_run_ext      = {{(COUNT_WIDTH+1-RUN_WIDTH){1'b0}}, w_run_len};
  assign w_unused_tdata = ^s_axis_tdata;

  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                     input logic [COUNT_WIDTH:0]   b);
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, a} + b;
    return sum[COUNT_WIDTH] ? SAT_MAX : sum[COUNT_WIDTH-1:0];
  endfunction

  always_comb begin
    w_s_hs       = (r_state == ST_ACCUM) && s_axis_tvalid;
    w_m_hs       = (r_state == ST_EMIT) && m_axis_tready;
    w_last_beat  = (r_idx == IDX_W'(NUM_OUT));
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM: if (w_s_hs && (w_run_len == '0)) w_state_next = ST_EMIT;
      ST_EMIT:  if (w_m_hs && w_last_beat)       w_state_next = ST_ACCUM;
      default:  w_state_next = ST_ACCUM;
    endcase
  end

  // Result frame word order: count[0..NUM_OUT-1], then the cycle total.
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) w_words[i] = r_count[i];
    w_words[NUM_OUT] = r_cycles;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_state <= ST_ACCUM;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < NUM_OUT; i++) r_count[i] <= '0;
      r_cycles <= '0;
      r_idx    <= '0;
    end else if (w_s_hs && (w_run_len != '0)) begin
      for (int i = 0; i < NUM_OUT; i++)
        if (w_fire[i]) r_count[i] <= sat_add(r_count[i], w_run_ext);
      r_cycles <= sat_add(r_cycles, w_run_ext);
    end else if (w_m_hs) begin
      if (w_last_beat) begin
        for (int i = 0; i < NUM_OUT; i++) r_count[i] <= '0;
        r_cycles <= '0;
        r_idx    <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign s_axis_tready = (r_state == ST_ACCUM);
  assign m_axis_tvalid = (r_state == ST_EMIT);
  assign m_axis_tlast  = m_axis_tvalid && w_last_beat;
  assign m_axis_tdata  = m_axis_tvalid ? w_words[r_idx] : '0;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_axis_sink_decoder.sv
// Bench for axis_sink_decoder: two instances (16-bit and 8-bit counters) share one stimulus
// stream and are checked every cycle against a frame-level model, plus literal frame checks.
module tb_axis_sink_decoder;

  localparam int NO = 4;
  localparam int RW = 8;
  localparam int IW = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0] s_tdata;
  logic          s_tvalid;
  logic          m_tready;

  logic        s_tready16, m_tvalid16, m_tlast16, dbg16;
  logic [15:0] m_tdata16;
  logic        s_tready8, m_tvalid8, m_tlast8, dbg8;
  logic [7:0]  m_tdata8;

  axis_sink_decoder #(.NUM_OUT(NO), .RUN_WIDTH(RW), .IN_WIDTH(IW), .COUNT_WIDTH(16)) dut (
    .clk(clk), .arstn(arstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready16),
    .m_axis_tdata(m_tdata16), .m_axis_tvalid(m_tvalid16), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast16), .o_dbg_state(dbg16)
  );

  axis_sink_decoder #(.NUM_OUT(NO), .RUN_WIDTH(RW), .IN_WIDTH(IW), .COUNT_WIDTH(8)) dut8 (
    .clk(clk), .arstn(arstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready8),
    .m_axis_tdata(m_tdata8), .m_axis_tvalid(m_tvalid8), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast8), .o_dbg_state(dbg8)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: frame-level expectations ----------------
  int          cnt [NO];
  int          cyc;
  logic [15:0] exp_q16[$];
  logic [7:0]  exp_q8[$];

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      exp_q16.delete();
      exp_q8.delete();
      for (int i = 0; i < NO; i++) cnt[i] = 0;
      cyc = 0;
    end else if (exp_q16.size() == 0) begin
      if (s_tvalid) begin
        int          run;
        logic [NO-1:0] fire;
        run  = int'(s_tdata[IW-1 -: RW]);
        fire = s_tdata[IW-RW-1 -: NO];
        if (run == 0) begin
          for (int i = 0; i < NO; i++) begin
            exp_q16.push_back(16'(sat(cnt[i], 65535)));
            exp_q8.push_back(8'(sat(cnt[i], 255)));
            cnt[i] = 0;
          end
          exp_q16.push_back(16'(sat(cyc, 65535)));
          exp_q8.push_back(8'(sat(cyc, 255)));
          cyc = 0;
        end else begin
          for (int i = 0; i < NO; i++) if (fire[i]) cnt[i] += run;
          cyc += run;
        end
      end
    end else if (m_tready) begin
      void'(exp_q16.pop_front());
      void'(exp_q8.pop_front());
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (exp_q16.size() == 0) begin
      chk("cyc_s_tready16", s_tready16, 1);
      chk("cyc_m_tvalid16", m_tvalid16, 0);
      chk("cyc_m_tlast16",  m_tlast16,  0);
      chk("cyc_m_tdata16",  m_tdata16,  0);
      chk("cyc_s_tready8",  s_tready8,  1);
      chk("cyc_m_tvalid8",  m_tvalid8,  0);
    end else begin
      chk("cyc_s_tready16", s_tready16, 0);
      chk("cyc_m_tvalid16", m_tvalid16, 1);
      chk("cyc_m_tlast16",  m_tlast16,  32'(exp_q16.size() == 1));
      chk("cyc_m_tdata16",  m_tdata16,  exp_q16[0]);
      chk("cyc_s_tready8",  s_tready8,  0);
      chk("cyc_m_tvalid8",  m_tvalid8,  1);
      chk("cyc_m_tlast8",   m_tlast8,   32'(exp_q8.size() == 1));
      chk("cyc_m_tdata8",   m_tdata8,   exp_q8[0]);
    end
  end

  // ---------------- beat collector for literal frame checks ----------------
  logic [15:0] rx16[$];
  logic        rxl16[$];
  logic [7:0]  rx8[$];
  logic        rxl8[$];

  always @(negedge clk) begin
    if (arstn && m_tready) begin
      if (m_tvalid16) begin rx16.push_back(m_tdata16); rxl16.push_back(m_tlast16); end
      if (m_tvalid8)  begin rx8.push_back(m_tdata8);   rxl8.push_back(m_tlast8);   end
    end
  end

  task automatic clear_rx();
    rx16.delete(); rxl16.delete(); rx8.delete(); rxl8.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] run, input logic [3:0] fire);
    logic hs;
    int   n;
    s_tdata  = {run, fire, 4'($urandom_range(0, 15))};
    s_tvalid = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 50) begin
      hs = s_tready16;
      @(posedge clk); #1;
      n++;
    end
    chk("send_accepted", hs, 1);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_beats(input int nbeats);
    int n;
    n = 0;
    while (rx16.size() < nbeats && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_wait_in_budget", 32'(rx16.size() >= nbeats), 1);
  endtask

  task automatic chk_frame(input string name, input int e16[5], input int e8[5]);
    chk($sformatf("%s_len16", name), rx16.size(), NO + 1);
    chk($sformatf("%s_len8", name),  rx8.size(),  NO + 1);
    for (int i = 0; i < NO + 1; i++) begin
      if (i < rx16.size()) begin
        chk($sformatf("%s_w16[%0d]", name, i),    rx16[i],  e16[i]);
        chk($sformatf("%s_last16[%0d]", name, i), rxl16[i], 32'(i == NO));
      end
      if (i < rx8.size()) begin
        chk($sformatf("%s_w8[%0d]", name, i),     rx8[i],   e8[i]);
        chk($sformatf("%s_last8[%0d]", name, i),  rxl8[i],  32'(i == NO));
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    s_tdata  = '0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    arstn    = 1'b0;
    repeat (2) @(posedge clk); #1;

    chk("rst_s_tready", s_tready16, 1);
    chk("rst_m_tvalid", m_tvalid16, 0);
    chk("rst_m_tlast",  m_tlast16,  0);
    chk("rst_m_tdata",  m_tdata16,  0);
    chk("rst_dbg",      dbg16,      0);
    chk("rst_m_tvalid8", m_tvalid8, 0);
    arstn = 1'b1;
    @(posedge clk); #1;

    // basic accumulation
    clear_rx();
    send(8'd5, 4'b0001);
    send(8'd2, 4'b1001);
    send(8'd0, 4'b1111);
    wait_beats(NO + 1);
    chk_frame("t1", '{7, 0, 0, 2, 7}, '{7, 0, 0, 2, 7});

    // empty run
    clear_rx();
    send(8'd0, 4'b0101);
    wait_beats(NO + 1);
    chk_frame("t2", '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0});

    // saturation on the 8-bit instance
    clear_rx();
    send(8'd200, 4'b1111);
    send(8'd200, 4'b1111);
    send(8'd0, 4'b0000);
    wait_beats(NO + 1);
    chk_frame("t3", '{400, 400, 400, 400, 400}, '{255, 255, 255, 255, 255});

    // back-pressure during EMIT with a packet offered
    clear_rx();
    send(8'd3, 4'b0110);
    m_tready = 1'b0;
    send(8'd0, 4'b0000);
    s_tdata  = {8'd9, 4'b1111, 4'h0};
    s_tvalid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("t4_s_tready", s_tready16, 0);
      chk("t4_m_tvalid", m_tvalid16, 1);
      chk("t4_m_tdata",  m_tdata16,  0);
      chk("t4_m_tlast",  m_tlast16,  0);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    wait_beats(NO + 1);
    chk_frame("t4", '{0, 3, 3, 0, 3}, '{0, 3, 3, 0, 3});
    clear_rx();
    send(8'd0, 4'b0000);
    wait_beats(NO + 1);
    chk_frame("t4b", '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0});

    // back-to-back runs clear between frames
    clear_rx();
    send(8'd3, 4'b0100);
    send(8'd0, 4'b0000);
    wait_beats(NO + 1);
    chk_frame("t5a", '{0, 0, 3, 0, 3}, '{0, 0, 3, 0, 3});
    clear_rx();
    send(8'd1, 4'b0010);
    send(8'd0, 4'b0000);
    wait_beats(NO + 1);
    chk_frame("t5b", '{0, 1, 0, 0, 1}, '{0, 1, 0, 0, 1});

    // reset in the middle of a frame
    clear_rx();
    send(8'd4, 4'b0011);
    send(8'd0, 4'b0000);
    wait_beats(2);
    arstn = 1'b0;
    #2;
    chk("t6_m_tvalid_async", m_tvalid16, 0);
    chk("t6_s_tready_async", s_tready16, 1);
    chk("t6_m_tvalid8_async", m_tvalid8, 0);
    #4;
    arstn = 1'b1;
    @(posedge clk); #1;
    clear_rx();
    send(8'd0, 4'b0000);
    wait_beats(NO + 1);
    chk_frame("t6", '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0});

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
